// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: Q.24 degree angles, gain correction and the arctangent table.
package cordic_pkg;

  localparam int unsigned ANGLE_FRAC = 24;

  localparam logic [63:0] DEG_90  = 64'h0000_0000_5A00_0000;
  localparam logic [63:0] DEG_180 = 64'h0000_0000_B400_0000;
  localparam logic [63:0] DEG_360 = 64'h0000_0001_6800_0000;

  // 1/K for the accumulated micro-rotation gain, Q.24
  localparam logic [23:0] CORDIC_K_INV = 24'h9B74EE;

  typedef enum logic [1:0] {
    StIdle,
    StRot,
    StScale
  } cordic_state_e;

  // round(atan(2^-i) * 180/pi * 2^24)
  function automatic logic [31:0] atan_tab(input logic [4:0] idx);
    logic [31:0] val;
    case (idx)
      5'd0:    val = 32'h2D00_0000;
      5'd1:    val = 32'h1A90_A732;
      5'd2:    val = 32'h0E09_4740;
      5'd3:    val = 32'h0720_0112;
      5'd4:    val = 32'h0393_8AA6;
      5'd5:    val = 32'h01CA_3795;
      5'd6:    val = 32'h00E5_2A1B;
      5'd7:    val = 32'h0072_96D8;
      5'd8:    val = 32'h0039_4BA5;
      5'd9:    val = 32'h001C_A5DA;
      5'd10:   val = 32'h000E_52EE;
      5'd11:   val = 32'h0007_2977;
      5'd12:   val = 32'h0003_94BC;
      5'd13:   val = 32'h0001_CA5E;
      5'd14:   val = 32'h0000_E52F;
      5'd15:   val = 32'h0000_7297;
      5'd16:   val = 32'h0000_394C;
      5'd17:   val = 32'h0000_1CA6;
      5'd18:   val = 32'h0000_0E53;
      5'd19:   val = 32'h0000_0729;
      5'd20:   val = 32'h0000_0395;
      5'd21:   val = 32'h0000_01CA;
      5'd22:   val = 32'h0000_00E5;
      5'd23:   val = 32'h0000_0073;
      default: val = 32'h0000_0000;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/cordic_vectoring_if.sv
// Start/busy/done request channel of the vectoring engine.
interface cordic_vectoring_if #(
  parameter int unsigned W = 64
);
  logic                start;
  logic signed [W-1:0] x_in;
  logic signed [W-1:0] y_in;
  logic                busy;
  logic                done;
  logic        [W-1:0] mag;
  logic signed [W-1:0] angle;

  modport master (
    output start, x_in, y_in,
    input  busy, done, mag, angle
  );

  modport slave (
    input  start, x_in, y_in,
    output busy, done, mag, angle
  );
endinterface

// File: rtl/cordic_vec_stage.sv
// One combinational vectoring micro-rotation: drives y toward zero, accumulating angle in z.
module cordic_vec_stage
  import cordic_pkg::*;
#(
  parameter int unsigned W = 64
) (
  input  logic signed [W+1:0] x_i,
  input  logic signed [W+1:0] y_i,
  input  logic signed [W+1:0] z_i,
  input  logic        [4:0]   iter_i,
  output logic signed [W+1:0] x_o,
  output logic signed [W+1:0] y_o,
  output logic signed [W+1:0] z_o
);

  logic signed [W+1:0] x_sh;
  logic signed [W+1:0] y_sh;
  logic signed [W+1:0] atan_v;

  always_comb begin
    x_sh   = x_i >>> iter_i;
    y_sh   = y_i >>> iter_i;
    atan_v = (W+2)'(atan_tab(iter_i));
    if (!y_i[W+1]) begin
      x_o = x_i + y_sh;
      y_o = y_i - x_sh;
      z_o = z_i + atan_v;
    end else begin
      x_o = x_i - y_sh;
      y_o = y_i + x_sh;
      z_o = z_i - atan_v;
    end
  end

endmodule

// File: rtl/cordic_vectoring.sv
// Iterative CORDIC vectoring engine: (x, y) -> magnitude and atan2 angle in Q.24 degrees.
module cordic_vectoring
  import cordic_pkg::*;
#(
  parameter int unsigned W    = 64,
  parameter int unsigned ITER = 16
) (
  input logic               clk,
  input logic               rst,
  cordic_vectoring_if.slave bus
);

  localparam int unsigned WI = W + 2;
  localparam int unsigned PW = WI + 24;

  typedef logic signed [WI-1:0] ext_t;
  typedef logic signed [PW-1:0] prod_t;

  localparam ext_t  Deg90  = ext_t'(DEG_90);
  localparam ext_t  Deg180 = ext_t'(DEG_180);
  localparam ext_t  Deg360 = ext_t'(DEG_360);
  localparam prod_t MagMax = prod_t'({(W-1){1'b1}});

  cordic_state_e state_q, state_d;
  ext_t          x_q, x_d, y_q, y_d, z_q, z_d;
  logic [4:0]    iter_q, iter_d;
  logic          zero_q, zero_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [W-1:0]  mag_q, mag_d;
  logic [W-1:0]  angle_q, angle_d;

  ext_t  x_ext, y_ext;
  ext_t  x_rot, y_rot, z_rot;
  prod_t prod, scaled;

  assign x_ext = ext_t'(bus.x_in);
  assign y_ext = ext_t'(bus.y_in);

  cordic_vec_stage #(
    .W (W)
  ) u_stage (
    .x_i    (x_q),
    .y_i    (y_q),
    .z_i    (z_q),
    .iter_i (iter_q),
    .x_o    (x_rot),
    .y_o    (y_rot),
    .z_o    (z_rot)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      iter_q  <= '0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mag_q   <= '0;
      angle_q <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      iter_q  <= iter_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      mag_q   <= mag_d;
      angle_q <= angle_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start) state_d = StRot;
      StRot:   if (iter_q == 5'(ITER - 1)) state_d = StScale;
      StScale: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    iter_d  = iter_q;
    zero_d  = zero_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    mag_d   = mag_q;
    angle_d = angle_q;
    prod    = prod_t'(x_q) * prod_t'(CORDIC_K_INV);
    scaled  = prod >>> ANGLE_FRAC;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          iter_d = '0;
          busy_d = 1'b1;
          zero_d = (bus.x_in == '0) && (bus.y_in == '0);
          // Fold left half-plane into the right so the iterations converge
          if (!bus.x_in[W-1]) begin
            x_d = x_ext;
            y_d = y_ext;
            z_d = '0;
          end else if (!bus.y_in[W-1]) begin
            x_d = y_ext;
            y_d = -x_ext;
            z_d = Deg90;
          end else begin
            x_d = -y_ext;
            y_d = x_ext;
            z_d = -Deg90;
          end
        end
      end
      StRot: begin
        x_d    = x_rot;
        y_d    = y_rot;
        z_d    = z_rot;
        iter_d = iter_q + 5'd1;
      end
      StScale: begin
        done_d = 1'b1;
        busy_d = 1'b0;
        if (zero_q) begin
          mag_d   = '0;
          angle_d = '0;
        end else begin
          if (scaled > MagMax) begin
            mag_d = {1'b0, {(W-1){1'b1}}};
          end else if (scaled < 0) begin
            mag_d = '0;
          end else begin
            mag_d = scaled[W-1:0];
          end
          if (z_q <= -Deg180) begin
            angle_d = W'(z_q + Deg360);
          end else begin
            angle_d = W'(z_q);
          end
        end
      end
      default: ;
    endcase
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.mag   = mag_q;
  assign bus.angle = angle_q;

endmodule
